// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported memory between instruction fetch (IF) and data
//   access (DM). One requester is granted at a time; each access holds
//   mem_en for MEM_LAT cycles, paced by an internal down-counter. Read data
//   is latched on the last access cycle and a one-cycle done pulse follows.
//   A HALT observed while idle parks the arbiter until reset.
//
//   Optional feature macro: MEM_ARB_RR_EN
//     defined   : round-robin between IF and DM when both are pending
//     undefined : fixed data-over-fetch priority
//
// Ports
//   clk, rst (async, active-low)
//   halt                              park request from decode (level)
//   if_req, if_addr                   fetch request / address
//   if_rdata, if_done, if_stall       fetch response / completion / stall
//   dm_req, dm_wr, dm_addr, dm_wdata  data request (store when dm_wr=1)
//   dm_rdata, dm_done, dm_err         data response, misaligned flag
//   dm_stall                          data stage stall
//   mem_en, mem_wr, mem_addr,         memory macro interface
//   mem_wdata, mem_rdata
//   halted                            arbiter parked
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              dm_err,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              halted
);

  localparam int              CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_IF_ACC = 2'd1,
    S_DM_ACC = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             mem_wr_q;
  logic             grant_dm, grant_if, dm_misalign;
  logic             prefer_if;
  logic             acc_last;

  assign acc_last = (cnt == '0);

`ifdef MEM_ARB_RR_EN
  // Remembers whether the previous grant went to DM; reset value (IF) lets
  // data win the first tie. Misaligned data never grants, so it never
  // consumes a turn.
  logic last_dm;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_dm <= 1'b0;
    end else if (grant_dm) begin
      last_dm <= 1'b1;
    end else if (grant_if) begin
      last_dm <= 1'b0;
    end
  end

  assign prefer_if = last_dm & dm_req & if_req & ~halt;
`else
  assign prefer_if = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and grant decision; requests are only looked at in IDLE
  always_comb begin
    state_nx    = state;
    grant_dm    = 1'b0;
    grant_if    = 1'b0;
    dm_misalign = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (dm_req && dm_addr[0]) begin
          dm_misalign = 1'b1;
        end else if (dm_req && !prefer_if) begin
          grant_dm = 1'b1;
          state_nx = S_DM_ACC;
        end else if (if_req && !halt) begin
          grant_if = 1'b1;
          state_nx = S_IF_ACC;
        end else if (halt && !dm_req) begin
          state_nx = S_HALTED;
        end
      end
      S_IF_ACC, S_DM_ACC: begin
        if (acc_last) begin
          state_nx = S_IDLE;
        end
      end
      S_HALTED: state_nx = S_HALTED;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Outputs decoded from state; mem_en drops as soon as reset forces IDLE
  always_comb begin
    mem_en   = (state == S_IF_ACC) || (state == S_DM_ACC);
    mem_wr   = mem_wr_q && (state == S_DM_ACC);
    halted   = (state == S_HALTED);
    if_stall = if_req & ~if_done;
    dm_stall = dm_req & ~dm_done;
  end

  // Access capture, latency counter and response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      mem_wr_q  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
      dm_err    <= 1'b0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      dm_err  <= 1'b0;

      if (grant_dm) begin
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
        mem_wr_q  <= dm_wr;
        cnt       <= CNT_LOAD;
      end else if (grant_if) begin
        mem_addr <= if_addr;
        mem_wr_q <= 1'b0;
        cnt      <= CNT_LOAD;
      end else if ((state == S_IF_ACC || state == S_DM_ACC) && !acc_last) begin
        cnt <= cnt - 1'b1;
      end

      // Misaligned data resolves without touching memory
      if (dm_misalign) begin
        dm_done <= 1'b1;
        dm_err  <= 1'b1;
      end

      // Last access cycle: mem_rdata is valid now, done pulses next cycle
      if (state == S_IF_ACC && acc_last) begin
        if_rdata <= mem_rdata;
        if_done  <= 1'b1;
      end
      if (state == S_DM_ACC && acc_last) begin
        dm_done <= 1'b1;
        if (!mem_wr_q) begin
          dm_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          halt = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_done, if_stall;
  logic          dm_req = 1'b0;
  logic          dm_wr = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic [DW-1:0] dm_rdata;
  logic          dm_done, dm_err, dm_stall;
  logic          mem_en, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          halted;

  logic [DW-1:0] mem_model [256];
  int            en_cyc;
  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] if_q[$];
  logic [DW-1:0] dm_q[$];
  logic [DW-1:0] exp_v;
  logic [DW-1:0] last_dm = '0;
  logic          e;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .halt(halt),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_done(if_done), .if_stall(if_stall),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_err(dm_err), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .halted(halted)
  );

  always #5 clk = ~clk;

  // Memory read data is only meaningful in the last enabled cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) en_cyc <= 0;
    else      en_cyc <= mem_en ? en_cyc + 1 : 0;
  end
  assign mem_rdata = (mem_en && en_cyc == LAT - 1) ? mem_model[mem_addr[7:0]] : 16'hDEAD;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({if_rdata, dm_rdata, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_data got %h/%h/%h/%h want 0", if_rdata, dm_rdata, mem_addr, mem_wdata);
    end
    checks++;
    if ({if_done, if_stall, dm_done, dm_err, dm_stall, mem_en, mem_wr, halted} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00000000",
               {if_done, if_stall, dm_done, dm_err, dm_stall, mem_en, mem_wr, halted});
    end
    rst = 1'b1;
  endtask

  task automatic test_fetch();
    next_cycle();
    if_req = 1'b1; if_addr = 16'h0010; if_q.push_back(16'hABCD);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) next_cycle();
      #1;
      e = (c >= 1 && c <= LAT);
      checks++;
      if (mem_en !== e) begin errors++; $display("FAIL fetch_mem_en c=%0d got %b want %b", c, mem_en, e); end
      if (e) begin
        checks++;
        if (mem_addr !== 16'h0010 || mem_wr !== 1'b0) begin
          errors++; $display("FAIL fetch_addr c=%0d got %h wr=%b want 0010 wr=0", c, mem_addr, mem_wr);
        end
      end
      e = (c == LAT + 1);
      checks++;
      if (if_done !== e) begin errors++; $display("FAIL fetch_done c=%0d got %b want %b", c, if_done, e); end
      e = (c <= LAT);
      checks++;
      if (if_stall !== e) begin errors++; $display("FAIL fetch_stall c=%0d got %b want %b", c, if_stall, e); end
      if (if_done) begin
        checks++;
        if (if_q.size() == 0) begin errors++; $display("FAIL fetch_extra_done c=%0d got 1 want 0", c); end
        else begin
          exp_v = if_q.pop_front();
          if (if_rdata !== exp_v) begin errors++; $display("FAIL fetch_rdata got %h want %h", if_rdata, exp_v); end
        end
        if_req = 1'b0;
      end
    end
  endtask

  task automatic test_tie();
    next_cycle();
    if_req = 1'b1; if_addr = 16'h0030;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0020;
    dm_q.push_back(16'h5555); if_q.push_back(16'h7777);
    for (int c = 0; c < 12; c++) begin
      if (c > 0) next_cycle();
      #1;
      e = (c >= 1 && c <= 4) || (c >= 6 && c <= 9);
      checks++;
      if (mem_en !== e) begin errors++; $display("FAIL tie_mem_en c=%0d got %b want %b", c, mem_en, e); end
      if (e) begin
        exp_v = (c <= 4) ? 16'h0020 : 16'h0030;
        checks++;
        if (mem_addr !== exp_v) begin errors++; $display("FAIL tie_addr c=%0d got %h want %h", c, mem_addr, exp_v); end
      end
      e = (c == 5);
      checks++;
      if (dm_done !== e) begin errors++; $display("FAIL tie_dm_done c=%0d got %b want %b", c, dm_done, e); end
      e = (c == 10);
      checks++;
      if (if_done !== e) begin errors++; $display("FAIL tie_if_done c=%0d got %b want %b", c, if_done, e); end
      e = (c <= 9);
      checks++;
      if (if_stall !== e) begin errors++; $display("FAIL tie_if_stall c=%0d got %b want %b", c, if_stall, e); end
      e = (c <= 4);
      checks++;
      if (dm_stall !== e) begin errors++; $display("FAIL tie_dm_stall c=%0d got %b want %b", c, dm_stall, e); end
      if (dm_done && dm_q.size() != 0) begin
        exp_v = dm_q.pop_front(); last_dm = exp_v;
        checks++;
        if (dm_rdata !== exp_v) begin errors++; $display("FAIL tie_dm_rdata got %h want %h", dm_rdata, exp_v); end
        dm_req = 1'b0;
      end
      if (if_done && if_q.size() != 0) begin
        exp_v = if_q.pop_front();
        checks++;
        if (if_rdata !== exp_v) begin errors++; $display("FAIL tie_if_rdata got %h want %h", if_rdata, exp_v); end
        if_req = 1'b0;
      end
    end
  endtask

  // Both requesters held high: order of grants shows the tie policy
  task automatic test_back_to_back();
    int order[3];
    int n = 0;
    int dm_n = 0;
`ifdef MEM_ARB_RR_EN
    int exp_order[3] = '{1, 0, 1};
`else
    int exp_order[3] = '{1, 1, 0};
`endif
    next_cycle();
    if_req = 1'b1; if_addr = 16'h0032;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0022;
    dm_q.push_back(16'h2222); dm_q.push_back(16'h2222); if_q.push_back(16'h3232);
    for (int c = 0; c < 24; c++) begin
      if (c > 0) next_cycle();
      #1;
      if (dm_done || if_done) begin
        checks++;
        if (n >= 3 || c != (n + 1) * (LAT + 1)) begin
          errors++; $display("FAIL b2b_timing c=%0d got done#%0d want cycle %0d", c, n, (n + 1) * (LAT + 1));
        end else begin
          order[n] = dm_done ? 1 : 0;
          checks++;
          if (order[n] !== exp_order[n]) begin
            errors++; $display("FAIL b2b_order n=%0d got dm=%0d want dm=%0d", n, order[n], exp_order[n]);
          end
          n++;
        end
      end
      if (dm_done && dm_q.size() != 0) begin
        exp_v = dm_q.pop_front(); last_dm = exp_v;
        checks++;
        if (dm_rdata !== exp_v || dm_err !== 1'b0) begin
          errors++; $display("FAIL b2b_dm_rdata got %h err=%b want %h err=0", dm_rdata, dm_err, exp_v);
        end
        dm_n++;
        if (dm_n == 2) dm_req = 1'b0;
      end
      if (if_done && if_q.size() != 0) begin
        exp_v = if_q.pop_front();
        checks++;
        if (if_rdata !== exp_v) begin errors++; $display("FAIL b2b_if_rdata got %h want %h", if_rdata, exp_v); end
        if_req = 1'b0;
      end
    end
    checks++;
    if (n != 3 || dm_q.size() != 0 || if_q.size() != 0) begin
      errors++; $display("FAIL b2b_count got %0d dones want 3", n);
      dm_q.delete(); if_q.delete();
    end
    dm_req = 1'b0; if_req = 1'b0;
  endtask

  task automatic test_store();
    next_cycle();
    dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0040; dm_wdata = 16'h1234;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) next_cycle();
      #1;
      e = (c >= 1 && c <= LAT);
      checks++;
      if (mem_en !== e || mem_wr !== e) begin
        errors++; $display("FAIL store_strobe c=%0d got en=%b wr=%b want %b", c, mem_en, mem_wr, e);
      end
      if (e) begin
        checks++;
        if (mem_addr !== 16'h0040 || mem_wdata !== 16'h1234) begin
          errors++; $display("FAIL store_bus c=%0d got %h/%h want 0040/1234", c, mem_addr, mem_wdata);
        end
      end
      e = (c == LAT + 1);
      checks++;
      if (dm_done !== e) begin errors++; $display("FAIL store_done c=%0d got %b want %b", c, dm_done, e); end
      if (dm_done) begin
        checks++;
        if (dm_rdata !== last_dm || dm_err !== 1'b0) begin
          errors++; $display("FAIL store_rdata got %h err=%b want %h err=0", dm_rdata, dm_err, last_dm);
        end
        dm_req = 1'b0; dm_wr = 1'b0;
      end
    end
  endtask

  task automatic test_misaligned();
    next_cycle();
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0003;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) next_cycle();
      #1;
      checks++;
      if (mem_en !== 1'b0) begin errors++; $display("FAIL mis_mem_en c=%0d got %b want 0", c, mem_en); end
      e = (c == 1);
      checks++;
      if (dm_done !== e || dm_err !== e) begin
        errors++; $display("FAIL mis_done c=%0d got done=%b err=%b want %b", c, dm_done, dm_err, e);
      end
      if (dm_done) begin
        checks++;
        if (dm_rdata !== last_dm) begin errors++; $display("FAIL mis_rdata got %h want %h", dm_rdata, last_dm); end
        dm_req = 1'b0;
      end
    end
  endtask

  task automatic test_halt();
    next_cycle();
    if_req = 1'b1; if_addr = 16'h0010; if_q.push_back(16'hABCD);
    for (int c = 0; c < 14; c++) begin
      if (c > 0) next_cycle();
      if (c == 2) halt = 1'b1;
      if (c == 7) begin
        if_req = 1'b1; dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0020;
      end
      #1;
      e = (c >= 1 && c <= LAT);
      checks++;
      if (mem_en !== e) begin errors++; $display("FAIL halt_mem_en c=%0d got %b want %b", c, mem_en, e); end
      e = (c == LAT + 1);
      checks++;
      if (if_done !== e) begin errors++; $display("FAIL halt_if_done c=%0d got %b want %b", c, if_done, e); end
      e = (c >= LAT + 2);
      checks++;
      if (halted !== e) begin errors++; $display("FAIL halt_halted c=%0d got %b want %b", c, halted, e); end
      if (if_done && if_q.size() != 0) begin
        exp_v = if_q.pop_front();
        checks++;
        if (if_rdata !== exp_v) begin errors++; $display("FAIL halt_rdata got %h want %h", if_rdata, exp_v); end
        if_req = 1'b0;
      end
    end
    checks++;
    if (dm_done !== 1'b0) begin errors++; $display("FAIL halt_dm_served got %b want 0", dm_done); end
  endtask

  task automatic test_reset_mid();
    halt = 1'b0; if_req = 1'b0; dm_req = 1'b0;
    rst = 1'b0;
    next_cycle();
    #1;
    checks++;
    if (halted !== 1'b0) begin errors++; $display("FAIL rstmid_unpark got %b want 0", halted); end
    rst = 1'b1;
    next_cycle();
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0020;
    next_cycle();
    #1;
    checks++;
    if (mem_en !== 1'b1) begin errors++; $display("FAIL rstmid_started got %b want 1", mem_en); end
    next_cycle();
    rst = 1'b0; dm_req = 1'b0;
    #1;
    checks++;
    if (mem_en !== 1'b0 || mem_addr !== '0 || dm_done !== 1'b0 || halted !== 1'b0) begin
      errors++; $display("FAIL rstmid_ctrl got en=%b addr=%h done=%b want 0/0000/0", mem_en, mem_addr, dm_done);
    end
    checks++;
    if (if_rdata !== '0 || dm_rdata !== '0) begin
      errors++; $display("FAIL rstmid_rdata got %h/%h want 0000/0000", if_rdata, dm_rdata);
    end
    next_cycle();
    rst = 1'b1;
    next_cycle();
    if_req = 1'b1; if_addr = 16'h0010; if_q.push_back(16'hABCD);
    for (int c = 0; c < 7; c++) begin
      if (c > 0) next_cycle();
      #1;
      e = (c == LAT + 1);
      checks++;
      if (if_done !== e) begin errors++; $display("FAIL rstmid_fetch c=%0d got %b want %b", c, if_done, e); end
      if (if_done && if_q.size() != 0) begin
        exp_v = if_q.pop_front();
        checks++;
        if (if_rdata !== exp_v) begin errors++; $display("FAIL rstmid_rdata2 got %h want %h", if_rdata, exp_v); end
        if_req = 1'b0;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = 16'h0F00 | 16'(i);
    mem_model[8'h10] = 16'hABCD;
    mem_model[8'h20] = 16'h5555;
    mem_model[8'h30] = 16'h7777;
    mem_model[8'h22] = 16'h2222;
    mem_model[8'h32] = 16'h3232;
    test_reset();
    test_fetch();
    test_tie();
    test_back_to_back();
    test_store();
    test_misaligned();
    test_halt();
    test_reset_mid();
    checks++;
    if (if_q.size() != 0 || dm_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_left got %0d/%0d want 0/0", if_q.size(), dm_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
